// File: rtl/circle_plotter.sv
// rtl/circle_plotter.sv - Bresenham midpoint circle rasteriser with ready/plot pixel handshake.
// Define CIRCLE_PLOTTER_CLIP_EN to suppress off-screen pixels instead of wrapping them.
module circle_plotter #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int XMAX = 159,
    parameter int YMAX = 119,
    parameter int RMAX = 59,
    localparam int RW  = $clog2(RMAX + 1)
) (
    input  logic          CLOCK_50,
    input  logic          Reset,
    input  logic          start,
    input  logic [XW-1:0] xc,
    input  logic [YW-1:0] yc,
    input  logic [RW:0]   radius,
    input  logic [2:0]    colour_in,
    input  logic          plot_ready,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [2:0]    vga_colour,
    output logic          vga_plot,
    output logic          busy,
    output logic          done
);

    localparam int DW = RW + 4;
    localparam int PW = RW + 2;
    localparam logic [RW:0]          RMAX_W = (RW + 1)'(RMAX);
    localparam logic signed [DW-1:0] D3     = DW'(3);
    localparam logic signed [DW-1:0] D6     = DW'(6);
    localparam logic signed [DW-1:0] D10    = DW'(10);
    localparam logic signed [PW-1:0] ONE_P  = PW'(1);

    typedef enum logic [1:0] {IDLE, PLOT, STEP, FIN} state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         xc_q, xc_d;
    logic [YW-1:0]         yc_q, yc_d;
    logic [2:0]            colour_q, colour_d;
    logic signed [PW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [DW-1:0]  d_q, d_d;
    logic [2:0]            oct_q, oct_d;

    logic [RW-1:0]         r_sel;
    logic signed [XW:0]    ox_x, ox_y, off_x, sum_x;
    logic signed [YW:0]    oy_x, oy_y, off_y, sum_y;
    logic                  pix_ok;
    logic                  adv;
    logic signed [DW-1:0]  dx4, dxy4;
    logic signed [PW-1:0]  x_inc, y_dec;

    assign r_sel = (radius > RMAX_W) ? RMAX_W[RW-1:0] : radius[RW-1:0];

    // Octant bit 2 swaps the roles of x/y; bit 0 negates the x offset, bit 1 the y offset.
    assign ox_x  = (XW + 1)'(x_q);
    assign ox_y  = (XW + 1)'(y_q);
    assign oy_x  = (YW + 1)'(x_q);
    assign oy_y  = (YW + 1)'(y_q);
    assign off_x = oct_q[2] ? (oct_q[0] ? -ox_y : ox_y) : (oct_q[0] ? -ox_x : ox_x);
    assign off_y = oct_q[2] ? (oct_q[1] ? -oy_x : oy_x) : (oct_q[1] ? -oy_y : oy_y);
    assign sum_x = $signed({1'b0, xc_q}) + off_x;
    assign sum_y = $signed({1'b0, yc_q}) + off_y;

`ifdef CIRCLE_PLOTTER_CLIP_EN
    localparam logic signed [XW:0] XMAX_S = (XW + 1)'(XMAX);
    localparam logic signed [YW:0] YMAX_S = (YW + 1)'(YMAX);
    assign pix_ok = !sum_x[XW] && (sum_x <= XMAX_S) && !sum_y[YW] && (sum_y <= YMAX_S);
`else
    logic unused_msb;
    assign unused_msb = sum_x[XW] ^ sum_y[YW];
    assign pix_ok     = 1'b1;
`endif

    // Clipped octants are skipped without waiting on the sink.
    assign adv        = (state_q == PLOT) && (!pix_ok || plot_ready);
    assign vga_plot   = (state_q == PLOT) && pix_ok;
    assign vga_x      = (state_q == PLOT) ? sum_x[XW-1:0] : '0;
    assign vga_y      = (state_q == PLOT) ? sum_y[YW-1:0] : '0;
    assign vga_colour = (state_q == PLOT) ? colour_q : 3'd0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);

    assign dx4   = DW'(x_q) <<< 2;
    assign dxy4  = (DW'(x_q) - DW'(y_q)) <<< 2;
    assign x_inc = x_q + ONE_P;
    assign y_dec = y_q - ONE_P;

    always_comb begin
        state_d  = state_q;
        xc_d     = xc_q;
        yc_d     = yc_q;
        colour_d = colour_q;
        x_d      = x_q;
        y_d      = y_q;
        d_d      = d_q;
        oct_d    = oct_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = PLOT;
                    xc_d     = xc;
                    yc_d     = yc;
                    colour_d = colour_in;
                    x_d      = '0;
                    y_d      = $signed({{(PW - RW){1'b0}}, r_sel});
                    d_d      = D3 - ($signed({{(DW - RW){1'b0}}, r_sel}) <<< 1);
                    oct_d    = 3'd0;
                end
            end
            PLOT: begin
                if (adv) begin
                    oct_d = oct_q + 3'd1;
                    if (oct_q == 3'd7) begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                oct_d = 3'd0;
                x_d   = x_inc;
                if (d_q[DW-1]) begin
                    d_d = d_q + dx4 + D6;
                    state_d = (x_inc <= y_q) ? PLOT : FIN;
                end else begin
                    d_d = d_q + dxy4 + D10;
                    y_d = y_dec;
                    state_d = (x_inc <= y_dec) ? PLOT : FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state_q  <= IDLE;
            xc_q     <= '0;
            yc_q     <= '0;
            colour_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            d_q      <= '0;
            oct_q    <= '0;
        end else begin
            state_q  <= state_d;
            xc_q     <= xc_d;
            yc_q     <= yc_d;
            colour_q <= colour_d;
            x_q      <= x_d;
            y_q      <= y_d;
            d_q      <= d_d;
            oct_q    <= oct_d;
        end
    end

endmodule

// File: doc/circle_plotter.md
CIRCLE_PLOTTER -- requirements
Module: circle_plotter

Interface
REQ-001 SHALL have parameter XW, default 8, meaning the x coordinate width.
REQ-002 SHALL have parameter YW, default 7, meaning the y coordinate width.
REQ-003 SHALL have parameter XMAX, default 159, meaning the last visible column.
REQ-004 SHALL have parameter YMAX, default 119, meaning the last visible row.
REQ-005 SHALL have parameter RMAX, default 59, meaning the radius clamp; the radius register width is RW = $clog2(RMAX+1).
REQ-006 SHALL have port CLOCK_50, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: request to draw one circle.
REQ-009 SHALL have port xc, input, XW bits: centre x.
REQ-010 SHALL have port yc, input, YW bits: centre y.
REQ-011 SHALL have port radius, input, RW+1 bits: requested radius.
REQ-012 SHALL have port colour_in, input, 3 bits: circle colour.
REQ-013 SHALL have port plot_ready, input, 1 bit: sink accepts the current pixel.
REQ-014 SHALL have port vga_x, output, XW bits: pixel x.
REQ-015 SHALL have port vga_y, output, YW bits: pixel y.
REQ-016 SHALL have port vga_colour, output, 3 bits: pixel colour.
REQ-017 SHALL have port vga_plot, output, 1 bit: pixel valid.
REQ-018 SHALL have port busy, output, 1 bit: a drawing is in progress.
REQ-019 SHALL have port done, output, 1 bit: one-cycle pulse when a drawing ends.

Function
REQ-020 SHALL implement FSM states IDLE, PLOT, STEP, FIN.
- IDLE -> PLOT on start.
- PLOT -> STEP after octant 7 is accepted.
- STEP -> PLOT while x<=y, otherwise STEP -> FIN.
- FIN -> IDLE after one cycle.
REQ-021 SHALL, on start in IDLE, latch xc, yc, colour_in and r = min(radius, RMAX), and set x=0, y=r, d=3-2r, octant=0.
- d is a signed register of RW+4 bits.
REQ-022 SHALL ignore start while busy; a start pulse that coincides with FIN or with the final step is dropped.
REQ-023 SHALL, in PLOT, drive vga_plot=1 and emit octants 0..7 in order: (xc+x,yc+y), (xc-x,yc+y), (xc+x,yc-y), (xc-x,yc-y), (xc+y,yc+x), (xc-y,yc+x), (xc+y,yc-x), (xc-y,yc-x).
REQ-024 SHALL advance the octant only in a cycle where vga_plot && plot_ready; outputs hold stable while plot_ready=0.
REQ-025 SHALL, in STEP (one cycle, vga_plot=0), update using the old x and y:
- if d<0: d += 4x+6;
- else: d += 4(x-y)+10 and y -= 1;
- then x += 1 and octant=0.
REQ-026 SHALL compute coordinate sums at XW+1 / YW+1 bits, signed, before any clipping or wrapping.
REQ-027 SHALL, for r=0, emit the centre pixel 8 times and then finish.
REQ-028 SHALL assert busy in PLOT, STEP and FIN, and assert done only in FIN.
REQ-029 SHALL have pixel latency of 1 cycle from the start edge to the first vga_plot=1.

Reset
REQ-030 SHALL, while Reset=1 at a clock edge, force:
- state=IDLE;
- vga_plot=0, busy=0, done=0;
- vga_x=0, vga_y=0, vga_colour=0;
- x=0, y=0, d=0.
REQ-031 SHALL, on Reset mid-drawing, abandon the circle without a done pulse, and SHALL accept start again on the first cycle after Reset falls.

Configuration
REQ-032 SHALL use macro CIRCLE_PLOTTER_CLIP_EN to select off-screen handling.
- Defined: a point with x<0, x>XMAX, y<0 or y>YMAX has vga_plot=0 for that octant; the octant advances in one cycle regardless of plot_ready.
- Undefined: every point has vga_plot=1, with coordinates truncated to XW/YW bits (modulo wrap).

Verification
REQ-033 SHALL cover: xc=79, yc=59, radius=0, plot_ready=1 -> eight pixels (79,59), then a done pulse, busy=0 afterwards.
REQ-034 SHALL cover: xc=79, yc=59, radius=3 -> first octant set (79,62),(79,62),(79,56),(79,56),(82,59),(76,59),(82,59),(76,59); the pixel set matches a software Bresenham model; done after x>y.
REQ-035 SHALL cover: radius=63 -> r clamped to 59; pixel (79,118) appears and no y>118 appears.
REQ-036 SHALL cover: plot_ready toggled 0/1 at random -> identical pixel sequence to REQ-034, and outputs stable whenever ready=0.
REQ-037 SHALL cover: xc=2, yc=2, radius=5 -> with CLIP_EN no vga_plot at negative coordinates; without CLIP_EN, a wrapped pixel x=253 is plotted.
REQ-038 SHALL cover: Reset asserted on the fifth pixel -> next cycle all outputs are 0 and no done; a start the cycle after Reset falls draws normally.
